// File: rtl/bigsub_serial_pkg.sv
// Shared types and helpers for the word-serial multi-precision subtractor.
// Default geometry, FSM encoding and the 4-bit carry-lookahead slice function.
package bigsub_serial_pkg;

  localparam int DEF_W         = 32;
  localparam int DEF_NUM_WORDS = 128;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // One lookahead slice of a + ~b + cin; returns {cout, diff[3:0]}
  function automatic logic [4:0] cla4_sub(input logic [3:0] a,
                                          input logic [3:0] b,
                                          input logic       cin);
    logic [3:0] bn;
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    bn   = ~b;
    g    = a & bn;
    p    = a ^ bn;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/bigsub_serial_if.sv
// Stream bus for bigsub_serial: operand word pairs in, difference words out.
// m_zero exists only when BIGSUB_ZERO_EN is defined.
interface bigsub_serial_if #(
  parameter int W         = 32,
  parameter int NUM_WORDS = 128
);
  localparam int CW = $clog2(NUM_WORDS);

  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_a;
  logic [W-1:0]  s_b;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_d;
  logic [CW-1:0] m_idx;
  logic          m_last;
  logic          m_borrow;
`ifdef BIGSUB_ZERO_EN
  logic          m_zero;
`endif

  modport slave (
    input  s_valid, s_a, s_b, m_ready,
    output s_ready, m_valid, m_d, m_idx, m_last, m_borrow
`ifdef BIGSUB_ZERO_EN
    , output m_zero
`endif
  );

  modport master (
    output s_valid, s_a, s_b, m_ready,
    input  s_ready, m_valid, m_d, m_idx, m_last, m_borrow
`ifdef BIGSUB_ZERO_EN
    , input m_zero
`endif
  );

endinterface

// File: rtl/bigsub_serial_claa_sub_word.sv
// Combinational W-bit subtractor a + ~b + cin built from rippled 4-bit lookahead slices.
module bigsub_serial_claa_sub_word
  import bigsub_serial_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] d,
  output logic         cout
);
  localparam int NS = W / 4;

  logic [NS:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < NS; i++) begin : g_slice
    assign {c_s[i+1], d[4*i +: 4]} = cla4_sub(a[4*i +: 4], b[4*i +: 4], c_s[i]);
  end

  assign cout = c_s[NS];

endmodule

// File: rtl/bigsub_serial.sv
// Word-serial D = A - B over NUM_WORDS words, LS word first, registered borrow between words.
// Optional A == B flag on the last word when BIGSUB_ZERO_EN is defined.
module bigsub_serial
  import bigsub_serial_pkg::*;
#(
  parameter int W         = DEF_W,
  parameter int NUM_WORDS = DEF_NUM_WORDS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clr,
  bigsub_serial_if.slave bus
);
  localparam int            CW       = $clog2(NUM_WORDS);
  localparam logic [CW-1:0] LAST_IDX = CW'(NUM_WORDS - 1);

  state_t        state_r;
  state_t        state_nxt_s;
  logic [CW-1:0] idx_r;
  logic          borrow_r;
  logic          m_valid_r;
  logic [W-1:0]  m_d_r;
  logic [CW-1:0] m_idx_r;
  logic          m_last_r;
  logic          m_borrow_r;

  logic          s_ready_s;
  logic          accept_s;
  logic          first_s;
  logic          last_s;
  logic          cin_s;
  logic [W-1:0]  diff_s;
  logic          cout_s;

  assign s_ready_s = ~m_valid_r | bus.m_ready;
  assign accept_s  = bus.s_valid & s_ready_s;
  // IDLE coincides with idx == 0, so it marks the first word of an operand
  assign first_s   = (state_r == IDLE);
  assign last_s    = (idx_r == LAST_IDX);
  assign cin_s     = first_s ? 1'b1 : ~borrow_r;

  bigsub_serial_claa_sub_word #(.W(W)) u_sub (
    .a    (bus.s_a),
    .b    (bus.s_b),
    .cin  (cin_s),
    .d    (diff_s),
    .cout (cout_s)
  );

  // Next-state: leave IDLE on the first accept, return on accept of the last word
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = BUSY;
        else          state_nxt_s = IDLE;
      end
      BUSY: begin
        if (accept_s && last_s) state_nxt_s = IDLE;
        else                    state_nxt_s = BUSY;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n || clr) state_r <= IDLE;
    else               state_r <= state_nxt_s;
  end

  // Word counter, inter-word borrow and the one-entry output register
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      idx_r      <= {CW{1'b0}};
      borrow_r   <= 1'b0;
      m_valid_r  <= 1'b0;
      m_d_r      <= {W{1'b0}};
      m_idx_r    <= {CW{1'b0}};
      m_last_r   <= 1'b0;
      m_borrow_r <= 1'b0;
    end else if (accept_s) begin
      idx_r      <= last_s ? {CW{1'b0}} : idx_r + CW'(1);
      borrow_r   <= last_s ? 1'b0 : ~cout_s;
      m_valid_r  <= 1'b1;
      m_d_r      <= diff_s;
      m_idx_r    <= idx_r;
      m_last_r   <= last_s;
      m_borrow_r <= ~cout_s;
    end else if (bus.m_ready) begin
      m_valid_r  <= 1'b0;
    end
  end

  assign bus.s_ready  = s_ready_s;
  assign bus.m_valid  = m_valid_r;
  assign bus.m_d      = m_d_r;
  assign bus.m_idx    = m_idx_r;
  assign bus.m_last   = m_last_r;
  assign bus.m_borrow = m_borrow_r;

`ifdef BIGSUB_ZERO_EN
  logic zacc_r;
  logic m_zero_r;
  logic zacc_s;

  // Running "all difference words zero so far", restarted on word 0
  always_comb begin
    zacc_s = 1'b0;
    if (first_s) zacc_s = (diff_s == {W{1'b0}});
    else         zacc_s = zacc_r & (diff_s == {W{1'b0}});
  end

  // Zero accumulator and its flag, reported only on the last word
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      zacc_r   <= 1'b1;
      m_zero_r <= 1'b0;
    end else if (accept_s) begin
      zacc_r   <= last_s ? 1'b1 : zacc_s;
      m_zero_r <= last_s & zacc_s;
    end
  end

  assign bus.m_zero = m_zero_r;
`endif

endmodule

// File: tb/tb_bigsub_serial.sv
// Scoreboard bench for bigsub_serial (W=32, NUM_WORDS=4); checks m_zero when BIGSUB_ZERO_EN is defined.
module tb_bigsub_serial;
  localparam int W  = 32;
  localparam int NW = 4;

  typedef logic [31:0] op_t [4];
  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  idx;
    logic        last;
    logic        borrow;
    logic        zero;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clr   = 1'b0;

  always #5 clk = ~clk;

  bigsub_serial_if #(.W(W), .NUM_WORDS(NW)) bus ();

  bigsub_serial #(.W(W), .NUM_WORDS(NW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  exp_t q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  int   cyc       = 0;
  bit   acc_log   = 1'b0;
  int   stamps[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every presented word is compared against the queue head (also while stalled)
  always @(negedge clk) begin
    if (rst_n && !clr && bus.m_valid) begin
      if (q.size() == 0) begin
        check("spurious_output_queue_size", 64'(q.size()), 64'd1);
      end else begin
        check($sformatf("word_idx%0d {d,idx,last,borrow}", q[0].idx),
              {bus.m_d, bus.m_idx, bus.m_last, bus.m_borrow},
              {q[0].d, q[0].idx, q[0].last, q[0].borrow});
`ifdef BIGSUB_ZERO_EN
        check($sformatf("word_idx%0d m_zero", q[0].idx), 64'(bus.m_zero), 64'(q[0].zero));
`endif
        if (bus.m_ready) void'(q.pop_front());
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    bus.s_valid = 1'b1;
    bus.s_a     = a;
    bus.s_b     = b;
    @(negedge clk);
    while (!bus.s_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.s_ready) check("send_accept_timeout", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    if (acc_log) stamps.push_back(cyc);
    #1;
    bus.s_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [31:0] d, input int i, input logic br, input logic zl);
    exp_t e;
    e.d      = d;
    e.idx    = 2'(i);
    e.last   = (i == 3);
    e.borrow = br;
    e.zero   = (i == 3) ? zl : 1'b0;
    q.push_back(e);
  endtask

  task automatic send_op(input op_t a, input op_t b, input op_t d,
                         input logic [3:0] br, input logic zl);
    for (int i = 0; i < 4; i++) begin
      push_exp(d[i], i, br[i], zl);
      send(a[i], b[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain_queue_empty", 64'(q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_m_valid"},  64'(bus.m_valid),  64'd0);
    check({tag, "_m_d"},      64'(bus.m_d),      64'd0);
    check({tag, "_m_idx"},    64'(bus.m_idx),    64'd0);
    check({tag, "_m_last"},   64'(bus.m_last),   64'd0);
    check({tag, "_m_borrow"}, 64'(bus.m_borrow), 64'd0);
    check({tag, "_s_ready"},  64'(bus.s_ready),  64'd1);
  endtask

  // Abort after word 1 of a borrowing operand, then a fresh operand must restart at idx 0, cin 1
  task automatic mid_abort(input bit use_clr);
    push_exp(32'hFFFF_FFFF, 0, 1'b1, 1'b0);
    send(32'd0, 32'd1);
    push_exp(32'hFFFF_FFFF, 1, 1'b1, 1'b0);
    send(32'd0, 32'd0);
    if (use_clr) clr = 1'b1;
    else         rst_n = 1'b0;
    check(use_clr ? "clr_pending_words" : "rst_pending_words", 64'(q.size()), 64'd1);
    q.delete();
    @(posedge clk);
    #1;
    clr   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_idle(use_clr ? "after_clr" : "after_rst");
    @(posedge clk);
    #1;
    send_op('{32'd5, 32'd0, 32'd0, 32'd0}, '{32'd3, 32'd0, 32'd0, 32'd0},
            '{32'd2, 32'd0, 32'd0, 32'd0}, 4'b0000, 1'b0);
    drain();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: still running at 200000, limit 200000");
    $fatal(1);
  end

  initial begin
    bus.s_valid = 1'b0;
    bus.s_a     = 32'd0;
    bus.s_b     = 32'd0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 5 - 3 in the LS word, no borrow anywhere
    send_op('{32'd5, 32'd0, 32'd0, 32'd0}, '{32'd3, 32'd0, 32'd0, 32'd0},
            '{32'd2, 32'd0, 32'd0, 32'd0}, 4'b0000, 1'b0);
    drain();

    // 0 - 1: borrow ripples through every word
    send_op('{32'd0, 32'd0, 32'd0, 32'd0}, '{32'd1, 32'd0, 32'd0, 32'd0},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'b1111, 1'b0);
    drain();

    // A == B
    send_op('{32'hDEAD_BEEF, 32'd1, 32'd2, 32'd3}, '{32'hDEAD_BEEF, 32'd1, 32'd2, 32'd3},
            '{32'd0, 32'd0, 32'd0, 32'd0}, 4'b0000, 1'b1);
    drain();

    // m_ready toggling every cycle while the source streams
    fork
      begin
        repeat (24) begin
          @(posedge clk);
          #1;
          bus.m_ready = ~bus.m_ready;
        end
      end
      send_op('{32'd0, 32'd5, 32'd0, 32'd7}, '{32'd1, 32'd5, 32'd0, 32'd2},
              '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd4}, 4'b0111, 1'b0);
    join
    bus.m_ready = 1'b1;
    drain();

    // Two operands back-to-back: second starts clean despite the first ending in a borrow
    acc_log = 1'b1;
    send_op('{32'd1, 32'd0, 32'd0, 32'd0}, '{32'd2, 32'd0, 32'd0, 32'd0},
            '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF}, 4'b1111, 1'b0);
    send_op('{32'd8, 32'd0, 32'd0, 32'd0}, '{32'd3, 32'd0, 32'd0, 32'd0},
            '{32'd5, 32'd0, 32'd0, 32'd0}, 4'b0000, 1'b0);
    acc_log = 1'b0;
    drain();
    check("b2b_accept_count", 64'(stamps.size()), 64'd8);
    if (stamps.size() == 8) check("b2b_accept_span_cycles", 64'(stamps[7] - stamps[0]), 64'd7);

    mid_abort(1'b0);
    mid_abort(1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
